// File: rtl/demux_1to4.sv
// 1-to-4 stream demux: each accepted word goes to lane in_sel through a 2-entry FIFO.
// One cycle to the lane head; only a full destination lane drops in_ready.

// 2-entry FIFO with registered head; head reads zero when empty.
// Pop at full frees the slot from the next cycle only.
module demux_fifo2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (occ != 2'd0);
  assign full     = (occ == 2'd2);
  assign do_pop   = pop && head_vld;
  assign do_push  = push && !full;
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

module demux_1to4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             out_a_valid,
  output logic             out_b_valid,
  output logic             out_c_valid,
  output logic             out_d_valid,
  input  logic             out_a_ready,
  input  logic             out_b_ready,
  input  logic             out_c_ready,
  input  logic             out_d_ready,
  output logic [3:0]       lane_full
);

  logic [3:0]       lane_rdy;
  logic [3:0]       lane_vld;
  logic [3:0]       lane_push;
  logic [WIDTH-1:0] lane_dat [4];

  // Ready depends only on in_sel and registered fullness, never on downstream ready.
  assign in_ready = rst_n && !lane_full[in_sel];
  assign lane_rdy = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_push[i] = in_valid && in_ready && (in_sel == 2'(i));

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (lane_push[i]),
      .push_dat (in_data),
      .pop      (lane_rdy[i]),
      .head_dat (lane_dat[i]),
      .head_vld (lane_vld[i]),
      .full     (lane_full[i])
    );
  end

  assign out_a       = lane_dat[0];
  assign out_b       = lane_dat[1];
  assign out_c       = lane_dat[2];
  assign out_d       = lane_dat[3];
  assign out_a_valid = lane_vld[0];
  assign out_b_valid = lane_vld[1];
  assign out_c_valid = lane_vld[2];
  assign out_d_valid = lane_vld[3];

  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(in_sel));

endmodule

// File: doc/demux_1to4.md
Name: demux_1to4

Overview:
- 1-to-4 stream demultiplexer: the distribution counterpart of the 4-to-1 select mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input port, together with a 2-bit select.
- Routes each word to one of four output lanes (a/b/c/d).
- Each lane has a 2-entry FIFO, so a stalled lane never blocks traffic to the other lanes and a free lane sustains one word per cycle.

Parameters:
- WIDTH, 4, data width of the input word and of each output lane.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 2'b00=a, 01=b, 10=c, 11=d; qualified by in_valid.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept the word addressed by in_sel this cycle.
- out_a, out_b, out_c, out_d  output  WIDTH  head-of-FIFO data per lane.
- out_a_valid .. out_d_valid  output  1 each  lane FIFO non-empty.
- out_a_ready .. out_d_ready  input  1 each  downstream accepts lane head.
- lane_full  output  4  bit0=a .. bit3=d; lane FIFO holds 2 entries.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All lane FIFOs emptied; out_x_valid=0; out_x=0; lane_full=4'b0000.
  - in_ready is low while rst_n=0.
  - Reset mid-operation discards all buffered words, with no partial delivery.
- Input handshake:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = rst_n && !lane_full[in_sel]; combinational from in_sel and registered state only, with no path from any out_x_ready.
  - in_sel with X/unknown while in_valid=1 is illegal (assertion); no word is written.
  - While in_valid=0, no write occurs regardless of in_ready.
- Output handshake per lane:
  - Pop when out_x_valid && out_x_ready at a rising edge.
  - out_x shows the FIFO head and is held stable while out_x_valid=1 and out_x_ready=0.
  - Data is driven from registers; out_x=0 when the lane is empty.
- Latency: a word accepted at edge N appears on its lane with out_x_valid=1 after edge N (one cycle), if that lane was empty.
- Ordering: per-lane FIFO order preserved; no ordering guarantee across lanes.
- Per-lane FIFO: 2 entries, occupancy 0/1/2.
  - push&&!pop: occ+1.
  - pop&&!push: occ-1.
  - push&&pop: occ unchanged; the head advances and the new word goes to the tail.
  - push && pop at occ=1: the new word becomes head next cycle.
  - push at occ=2: impossible, because in_ready is low. A pop at occ=2 frees a slot only from the next cycle; no same-cycle pass-through.
  - pop at occ=0: ignored, because out_x_valid=0.
- Throughput:
  - One word per cycle to any lane whose downstream is always ready.
  - Alternating lanes also sustain one word per cycle.
  - A full lane stalls only words addressed to it (head-of-line blocking at the input is accepted by design).
- lane_full[i] = (occ_i==2), registered-state derived.
- Pointers wrap modulo 2; occupancy never exceeds 2 or underflows (assertions required).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, all out_x_valid=0, out_x=4'h0, lane_full=0; release -> in_ready=1.
- Routing: send 4'h1/sel0, 4'h2/sel1, 4'h3/sel2, 4'h4/sel3 on consecutive cycles, all lanes ready -> out_a=1, out_b=2, out_c=3, out_d=4, each valid exactly one cycle, one cycle after acceptance.
- Backpressure: out_b_ready=0, send 4'hA, 4'hB, 4'hC to sel1 -> first two accepted, lane_full=4'b0010, in_ready=0 for 4'hC. Raise out_b_ready -> outputs A then B, then C accepted the cycle after first pop.
- Non-blocking: lane a full (out_a_ready=0), in_sel=2'b11 stream of 4'h5..4'h8 -> in_ready=1 each cycle, out_d delivers 5,6,7,8 in order while lane a holds its two words.
- Simultaneous push/pop: lane c occ=1 with head 4'h9, push 4'hE with out_c_ready=1 -> next cycle out_c=4'hE, occ=1, out_c_valid stays 1.
- Reset mid-operation: lanes a and d full, assert rst_n=0 for one edge -> all valids 0, lane_full=0, previously buffered words never appear.
